// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - projectile register file: spawn on fire, per-frame move/retire, sprite render.
module bullet_pool #(
    parameter int          MAX_BULLETS  = 16,
    parameter int          X_W          = 12,
    parameter int          Y_W          = 11,
    parameter int          BULLET_W     = 2,
    parameter int          BULLET_H     = 6,
    parameter int          SPEED        = 4,
    parameter int          COOLDOWN     = 8,
    parameter logic [23:0] BULLET_COLOR = 24'hFF2020
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               fire_n,
    input  logic [X_W-1:0]                     x_axis,
    input  logic [Y_W-1:0]                     y_axis,
    input  logic                               frame_start,
    input  logic                               blank,
    input  logic [X_W-1:0]                     display_col,
    input  logic [Y_W-1:0]                     display_row,
    output logic [24:0]                        bullet_color,
    output logic [$clog2(MAX_BULLETS+1)-1:0]   active_count,
    output logic                               fire_dropped,
    output logic                               busy
);
    localparam int IDX_W = $clog2(MAX_BULLETS);
    localparam int CNT_W = $clog2(MAX_BULLETS + 1);
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BULLETS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       move_idx;
    logic [MAX_BULLETS-1:0] valid;
    logic [X_W-1:0]         pos_x [MAX_BULLETS];
    logic [Y_W-1:0]         pos_y [MAX_BULLETS];
    logic [CD_W-1:0]        cooldown;
    logic                   fire_pending;

    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic [CNT_W-1:0]       slot_count;
    logic                   hit;

    // Descending scan so the last assignment leaves the lowest free index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        slot_count = '0;
        for (int i = 0; i < MAX_BULLETS; i++)
            slot_count = slot_count + CNT_W'(valid[i]);
    end

    // Bounds compared one bit wider so a sprite at the right/bottom edge does not wrap.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            if (valid[i]
                && ({1'b0, display_col} >= {1'b0, pos_x[i]})
                && ({1'b0, display_col} <= {1'b0, pos_x[i]} + (X_W+1)'(BULLET_W - 1))
                && ({1'b0, display_row} >= {1'b0, pos_y[i]})
                && ({1'b0, display_row} <= {1'b0, pos_y[i]} + (Y_W+1)'(BULLET_H - 1)))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            move_idx     <= '0;
            valid        <= '0;
            for (int i = 0; i < MAX_BULLETS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
            cooldown     <= '0;
            fire_pending <= 1'b0;
            fire_dropped <= 1'b0;
            busy         <= 1'b0;
            active_count <= '0;
            bullet_color <= '0;
        end else begin
            fire_dropped <= 1'b0;
            active_count <= slot_count;
            bullet_color <= (hit && !blank) ? {BULLET_COLOR, 1'b1} : 25'b0;
            if (!fire_n)
                fire_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= MOVE;
                        move_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                MOVE: begin
                    if (valid[move_idx]) begin
                        if (pos_y[move_idx] < Y_W'(SPEED))
                            valid[move_idx] <= 1'b0;
                        else
                            pos_y[move_idx] <= pos_y[move_idx] - Y_W'(SPEED);
                    end
                    if (move_idx == LAST_IDX)
                        state <= SPAWN;
                    else
                        move_idx <= move_idx + IDX_W'(1);
                end
                SPAWN: begin
                    if (cooldown != '0) begin
                        cooldown <= cooldown - CD_W'(1);
                    end else if (fire_pending && free_found) begin
                        valid[free_idx] <= 1'b1;
                        pos_x[free_idx] <= x_axis;
                        pos_y[free_idx] <= y_axis;
                        cooldown        <= CD_W'(COOLDOWN);
                    end else if (fire_pending) begin
                        fire_dropped <= 1'b1;
                    end
                    fire_pending <= 1'b0;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
Parametrised projectile manager for the VGA shooter. Holds up to MAX_BULLETS independent bullets in a register file, spawns them from the player position on fire, advances and retires them once per frame during vertical blank, and renders multi-pixel bullet sprites into the pixel stream. Sits between the input/player logic and the pixel mixer.

Parameters:
MAX_BULLETS, 16, number of slots (2..64)
X_W, 12, column coordinate width
Y_W, 11, row coordinate width
BULLET_W, 2, sprite width in pixels
BULLET_H, 6, sprite height in pixels
SPEED, 4, rows moved upward per frame
COOLDOWN, 8, frames blocked after a spawn
BULLET_COLOR, 24'hFF2020, RGB888 sprite colour

Ports:
clock  in  1  system/pixel clock
reset  in  1  synchronous, active-high
fire_n  in  1  fire button, active-low level
x_axis  in  X_W  spawn column (player x)
y_axis  in  Y_W  spawn row (player y)
frame_start  in  1  one-cycle pulse at start of vertical blank
blank  in  1  high outside visible area
display_col  in  X_W  current pixel column
display_row  in  Y_W  current pixel row
bullet_color  out  25  {RGB888, hit}; hit=bit0
active_count  out  clog2(MAX_BULLETS+1)  valid slots
fire_dropped  out  1  one-cycle pulse: fire lost (pool full)
busy  out  1  high while FSM not IDLE

Behaviour:
- Reset (clock "clock", reset "reset": synchronous, active-high): all slot valid bits 0, x/y 0, cooldown 0, fire_pending 0, FSM IDLE, bullet_color 0, active_count 0, fire_dropped 0, busy 0.
- fire_pending: set any cycle fire_n==0 sampled; cleared only in SPAWN.
- FSM IDLE -> MOVE on frame_start; frame_start while not IDLE ignored.
- MOVE: one slot per cycle, idx 0..MAX_BULLETS-1. Valid slot: if y < SPEED -> valid=0 (retire, no wrap), else y -= SPEED. Invalid slot untouched. After idx MAX_BULLETS-1 -> SPAWN.
- SPAWN (1 cycle): if cooldown!=0 -> cooldown-=1, no spawn. Else if fire_pending and free slot -> lowest-index free slot gets {x_axis, y_axis}, valid=1, cooldown=COOLDOWN. Else if fire_pending and pool full -> fire_dropped pulses this cycle. fire_pending cleared in all cases. -> IDLE.
- Pass length MAX_BULLETS+1 cycles; must finish within blank (not checked by block).
- busy = (state != IDLE).
- active_count: registered popcount of valid bits, updated the cycle after any change.
- Render: hit when any valid slot satisfies x <= display_col <= x+BULLET_W-1 and y <= display_row <= y+BULLET_H-1 (compare at X_W+1/Y_W+1 bits, no overflow). Registered: bullet_color={BULLET_COLOR,1'b1} on hit, else 25'b0; latency 1 cycle from display_col/row. blank==1 forces 0.
- Overlapping bullets render identically to one. Slot updates during visible area impossible (MOVE only after frame_start); reset mid-pass abandons pass, clears all.

Test Plan:
- Reset then idle 3 frames -> bullet_color 0, active_count 0, busy 0 throughout.
- fire_n low 1 cycle, x_axis=320,y_axis=400, frame_start -> slot0 at (320,400), active_count=1 after SPAWN; next frame y=396; pixel (321,401) hit=1 with color FF2020, (322,396) hit=0.
- Hold fire_n low 20 frames, COOLDOWN=8 -> spawns at frames 1,10,19 only (cooldown counts 8 frames), active_count=3.
- Bullet at y=3, SPEED=4, frame_start -> retired, active_count decrements, never reappears at y≈2047.
- MAX_BULLETS=4, COOLDOWN=0, fire every frame, bullets far from top -> 4 spawns, 5th frame fire_dropped=1 one cycle, active_count stays 4.
- Assert reset mid-MOVE (busy=1) -> next cycle busy=0, all slots invalid, no hits rendered; frame_start during busy ignored (pass length stays MAX_BULLETS+1).
